// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 16-bit pipelined processor.
// Holds the PC, drives the instruction-memory address and loads the IF/ID
// pipeline register. Redirects come from decode (jump) and execute (taken
// branch); the hazard unit can stall or flush; a stop in decode halts fetch
// until reset.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           IMM8_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_IF_ID_i,
  input  logic                  flush_IF_ID_i,
  input  logic                  Jump_i,
  input  logic [IMM8_WIDTH-1:0] jumpAddr_i,
  input  logic                  BranchTaken_i,
  input  logic [ADDR_WIDTH-1:0] branchAddr_i,
  input  logic                  Stop_i,
  output logic [ADDR_WIDTH-1:0] instruction_mem_addr_o,
  input  logic [DATA_WIDTH-1:0] instruction_mem_rD_i,
  output logic [ADDR_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] instruction_D_o,
  output logic                  validD_o,
  output logic                  halted_o,
  output logic [15:0]           fetch_cnt_o,
  output logic [15:0]           bubble_cnt_o
);

  typedef enum logic {FETCH, HALT} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic                  load_valid;
  logic                  load_bubble;

  assign instruction_mem_addr_o = pc;
  assign halted_o               = (state == HALT);

  // Next-state, next-PC and IF/ID load selection.
  // Branch is tested before stall so a resolved branch is never lost;
  // halting is decided independently of the PC priority chain.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    case (state)
      FETCH: begin
        if (Stop_i && !BranchTaken_i && !stall_IF_ID_i) begin
          state_next = HALT;
        end
        if (BranchTaken_i) begin
          pc_next     = branchAddr_i;
          load_bubble = 1'b1;
        end else if (stall_IF_ID_i) begin
          pc_next = pc;
        end else if (Jump_i) begin
          pc_next     = ADDR_WIDTH'(jumpAddr_i);
          load_bubble = 1'b1;
        end else if (Stop_i) begin
          pc_next     = pc;
          load_bubble = 1'b1;
        end else begin
          pc_next    = pc + ADDR_WIDTH'(1);
          load_valid = !flush_IF_ID_i;
          load_bubble = flush_IF_ID_i;
        end
      end
      HALT: begin
        load_bubble = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // State and program-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // IF/ID pipeline register; holds when neither a valid nor a bubble load occurs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCD_o           <= '0;
      instruction_D_o <= NOP_INSTR;
      validD_o        <= 1'b0;
    end else if (load_valid) begin
      PCD_o           <= pc;
      instruction_D_o <= instruction_mem_rD_i;
      validD_o        <= 1'b1;
    end else if (load_bubble) begin
      PCD_o           <= '0;
      instruction_D_o <= NOP_INSTR;
      validD_o        <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt, bubble_cnt;

  // Saturating counters of valid and bubble IF/ID loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (load_valid && (fetch_cnt != '1)) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      if (load_bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end
  end

  assign fetch_cnt_o  = fetch_cnt;
  assign bubble_cnt_o = bubble_cnt;
`else
  assign fetch_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined processor. It holds the program counter, drives the instruction-memory address, and registers the fetched word and its PC into the IF/ID pipeline register that feeds the decode stage. It takes redirect requests from decode (jump) and execute (taken branch), obeys hazard-unit stall and flush requests, and freezes the machine when decode reports a stop instruction.

## Interface
- DATA_WIDTH, 16, instruction word width
- ADDR_WIDTH, 8, PC and instruction-memory address width
- IMM8_WIDTH, 8, jump target width; must equal ADDR_WIDTH
- NOP_INSTR, 16'h0000, word inserted into IF/ID as a bubble

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- stall_IF_ID_i  in  1  hazard unit: hold PC and IF/ID
- flush_IF_ID_i  in  1  hazard unit: load a bubble into IF/ID
- Jump_i  in  1  decode: the instruction in IF/ID is a jump
- jumpAddr_i  in  IMM8_WIDTH  decode: jump target
- BranchTaken_i  in  1  execute: branch resolved taken
- branchAddr_i  in  ADDR_WIDTH  execute: branch target
- Stop_i  in  1  decode: the instruction in IF/ID is a stop
- instruction_mem_addr_o  out  ADDR_WIDTH  equals PC register (combinational)
- instruction_mem_rD_i  in  DATA_WIDTH  instruction memory read data, same cycle as address
- PCD_o  out  ADDR_WIDTH  IF/ID: PC of the held instruction
- instruction_D_o  out  DATA_WIDTH  IF/ID: held instruction
- validD_o  out  1  IF/ID: 1 = real instruction, 0 = bubble
- halted_o  out  1  1 while in HALT
- fetch_cnt_o  out  16  instructions loaded into IF/ID (see Configuration)
- bubble_cnt_o  out  16  bubbles loaded into IF/ID (see Configuration)

## Operation
- States: FETCH and HALT. Reset enters FETCH. FETCH moves to HALT when Stop_i=1, BranchTaken_i=0 and stall_IF_ID_i=0. HALT exits only through reset.
- Next-PC priority in FETCH: BranchTaken_i selects branchAddr_i, then stall holds the PC, then Jump_i selects jumpAddr_i, then Stop_i holds the PC, otherwise PC+1. PC+1 wraps modulo 2^ADDR_WIDTH, so 8'hFF goes to 8'h00.
- IF/ID priority in FETCH: BranchTaken_i loads a bubble, then stall holds, then flush_IF_ID_i, Jump_i or Stop_i loads a bubble, otherwise it loads {PC, instruction_mem_rD_i, valid=1}.
- A bubble is PCD_o=0, instruction_D_o=NOP_INSTR, validD_o=0.
- BranchTaken_i overrides stall. A branch resolved in execute is never lost, and a concurrent Jump_i or Stop_i is wrong-path and ignored.
- HALT: the PC is frozen, IF/ID is loaded with a bubble every cycle, halted_o=1, and all inputs are ignored.

## Timing
- Reset values: PC=0, PCD_o=0, instruction_D_o=NOP_INSTR, validD_o=0, halted_o=0, both counters 0, state FETCH.
- Reset is asserted asynchronously. Deassertion is sampled on the next posedge; the first cycle after reset fetches address 0.
- Fetch-to-IF/ID latency is 1 cycle.
- Jump penalty: 1 bubble. The target is fetched in the cycle after Jump_i.
- Taken-branch penalty: the IF/ID entry is bubbled and the target is fetched in the cycle after BranchTaken_i. Flushing ID/EX is the hazard unit's job.
- Stall plus flush in the same cycle: stall wins.
- Reset asserted mid-stall or in HALT returns everything to the reset values immediately.

## Configuration
- IF_PERF_CNT_EN defined:
  - fetch_cnt_o increments on each valid IF/ID load.
  - bubble_cnt_o increments on each bubble load, including in HALT.
  - Both counters are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- IF_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Sequential fetch: memory[i]=16'h1000+i, no hazards. IF/ID shows PCD_o=0,1,2,… with matching words and validD_o=1; PC wraps from 8'hFF to 8'h00.
- Jump: Jump_i=1 with jumpAddr_i=8'h40 while PCD_o=5. The next IF/ID entry is a bubble, the one after is PCD_o=8'h40, and instruction_mem_addr_o=8'h40 one cycle after Jump_i.
- Branch overrides stall: stall_IF_ID_i=1 and BranchTaken_i=1 with branchAddr_i=8'h20 in the same cycle. The PC becomes 8'h20 and IF/ID is loaded with a bubble, not held.
- Stall and flush: stall for 3 cycles, then flush for 1 cycle. IF/ID and PC hold for exactly 3 cycles, then one bubble is loaded; a simultaneous stall+flush cycle holds.
- Stop: Stop_i=1 at PC=8'h10. halted_o=1 the next cycle and the PC stays at 8'h10 for 10 cycles while bubbles are loaded. Stop_i together with BranchTaken_i does not halt.
- Reset mid-operation: drop rst while in HALT. Outputs go to the reset values asynchronously and fetching restarts at address 0. With IF_PERF_CNT_EN defined, the counters read 0 after reset.
